fifo_rd_drain: RTL

//  Read-side controller for the fifo block: drives RREQ from e, captures RD after the

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_skid.sv | 59 +++++
 rtl/fifo_rd_drain.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_pkg;

  // Default width of the FIFO read data word
  localparam int DATA_W_DFLT = 8;

  // FIFO read latency in clock cycles (RREQ accepted -> RD valid)
  localparam int READ_LAT = 1;

  // Read controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_t;

  // Words currently owned by the controller: buffered plus the one in flight.
  // Bounded to 0..3, so a 2-bit result never overflows.
  function automatic logic [1:0] owned_words(input logic [1:0] occ,
                                             input logic       pending);
    return occ + {1'b0, pending};
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry register buffer between the FIFO read port and the output stream.
// Entry 0 is always the head; entry 1 holds the word behind it.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [1:0]        o_occ,
  output logic [DATA_W-1:0] o_data
);

  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_mem0;
  logic [DATA_W-1:0] r_mem1;

  // Occupancy and storage update; a simultaneous push and pop keeps occ unchanged.
  // Push into a full buffer cannot happen: the caller's credit bound prevents it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ  <= 2'd0;
      r_mem0 <= '0;
      r_mem1 <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_mem0 <= i_data;
          end else begin
            r_mem1 <= i_data;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end else begin
            r_mem0 <= i_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_data = r_mem0;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side controller for the FIFO: issues RREQ under a two-word credit bound,
// captures RD one cycle after each accepted request into a skid buffer, and
// presents the words on a valid/ready stream. RREQ never depends on out_ready.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              e,
  output logic              RREQ,
  input  logic [DATA_W-1:0] RD,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  rd_count
);

  rd_state_t          r_state;
  rd_state_t          w_state_nxt;
  logic               r_pending;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         w_occ;
  logic [1:0]         w_owned;
  logic               w_rreq;
  logic               w_pop;
  logic [DATA_W-1:0]  w_head;

  // Credit bound: buffered plus in-flight words never exceed the two skid entries
  assign w_owned = owned_words(w_occ, r_pending);
  assign w_rreq  = (r_state == ACTIVE) & en & ~e & (w_owned < 2'd2);
  assign w_pop   = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DRAIN only retires once nothing is buffered or in flight
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!en) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (en) begin
          w_state_nxt = ACTIVE;
        end else if (!r_pending && (w_occ == 2'd0)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // In-flight flag: RD carries the requested word in the cycle after RREQ.
  // Clearing it on reset drops a word whose request was accepted before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_rreq;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_pop) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_pending),
    .i_pop  (w_pop),
    .i_data (RD),
    .o_occ  (w_occ),
    .o_data (w_head)
  );

  assign RREQ      = w_rreq;
  assign out_valid = (w_occ != 2'd0);
  assign out_data  = w_head;
  assign busy      = (r_state != IDLE);
  assign rd_count  = r_count;

endmodule
